// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - dot-product sequencer feeding an external MAC stage
// Optional macro MAC_SEQ_RELU_EN clamps negative results to zero at capture.
package mac_seq_pkg;
  localparam int Q_INT  = 8;
  localparam int Q_FRAC = 8;
  localparam int Q_W    = Q_INT + Q_FRAC;
endpackage

module mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] x_base,
  input  logic [ADDR_W-1:0] w_base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] x_addr,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [Q_W-1:0]    x_rdata,
  input  logic [Q_W-1:0]    w_rdata,
  output logic [Q_W-1:0]    mac_x,
  output logic [Q_W-1:0]    mac_w,
  output logic              mac_x_select,
  output logic              mac_w_select,
  output logic              mac_reg_enable,
  output logic              mac_acc_loopback,
  input  logic [Q_W-1:0]    mac,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [Q_W-1:0]    result,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  k_q, k_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] x_addr_q, x_addr_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic              rd_en_q, rd_en_d;
  logic              loop_q, loop_d;
  logic [Q_W-1:0]    result_q, result_d;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    len_d    = len_q;
    x_addr_d = x_addr_q;
    w_addr_d = w_addr_q;
    rd_en_d  = 1'b0;
    loop_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          if (len != '0) begin
            state_d  = FETCH;
            k_d      = '0;
            len_d    = len;
            x_addr_d = x_base;
            w_addr_d = w_base;
            rd_en_d  = 1'b1;
          end else begin
            state_d  = OUT;
            result_d = '0;
          end
        end
      end
      FETCH: begin
        // Data for element k returns next cycle; only element 0 starts a fresh sum.
        loop_d = (k_q != '0);
        if (k_q == len_q - LEN_W'(1)) begin
          state_d = DRAIN;
        end else begin
          rd_en_d  = 1'b1;
          k_d      = k_q + LEN_W'(1);
          x_addr_d = x_addr_q + ADDR_W'(1);
          w_addr_d = w_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
`ifdef MAC_SEQ_RELU_EN
        result_d = mac[Q_W-1] ? '0 : mac;
`else
        result_d = mac;
`endif
        state_d = OUT;
      end
      OUT: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      len_q    <= '0;
      x_addr_q <= '0;
      w_addr_q <= '0;
      rd_en_q  <= 1'b0;
      loop_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      len_q    <= len_d;
      x_addr_q <= x_addr_d;
      w_addr_q <= w_addr_d;
      rd_en_q  <= rd_en_d;
      loop_q   <= loop_d;
      result_q <= result_d;
    end
  end

  assign start_ready      = (state_q == IDLE);
  assign busy             = (state_q != IDLE);
  assign result_valid     = (state_q == OUT);
  assign result           = result_q;
  assign rd_en            = rd_en_q;
  assign x_addr           = x_addr_q;
  assign w_addr           = w_addr_q;
  assign mac_x            = x_rdata;
  assign mac_w            = w_rdata;
  assign mac_x_select     = 1'b1;
  assign mac_w_select     = 1'b1;
  assign mac_reg_enable   = 1'b0;
  assign mac_acc_loopback = loop_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// tb/tb_mac_sequencer.sv - scoreboard bench for mac_sequencer with memory and MAC stage models
module tb_mac_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid, start_ready;
  logic [7:0]  len, x_base, w_base;
  logic        rd_en;
  logic [7:0]  x_addr, w_addr;
  logic [15:0] x_rdata, w_rdata, mac_x, mac_w, mac, result;
  logic        mac_x_select, mac_w_select, mac_reg_enable, mac_acc_loopback;
  logic        result_valid, result_ready, busy;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int hs     = 0;

  logic [15:0] exp_q[$];
  int          lat_q[$];
  logic        lb_log[$];
  logic [7:0]  addr_log[$];

  logic [15:0]        x_mem[256];
  logic [15:0]        w_mem[256];
  logic [15:0]        acc;
  logic signed [31:0] prod;
  logic               rd_d;

`ifdef MAC_SEQ_RELU_EN
  localparam logic [15:0] NEG2_EXP = 16'h0000;
`else
  localparam logic [15:0] NEG2_EXP = 16'hFE00;
`endif

  mac_sequencer #(.ADDR_W(8), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .len(len), .x_base(x_base), .w_base(w_base),
    .rd_en(rd_en), .x_addr(x_addr), .w_addr(w_addr),
    .x_rdata(x_rdata), .w_rdata(w_rdata),
    .mac_x(mac_x), .mac_w(mac_w),
    .mac_x_select(mac_x_select), .mac_w_select(mac_w_select),
    .mac_reg_enable(mac_reg_enable), .mac_acc_loopback(mac_acc_loopback),
    .mac(mac),
    .result_valid(result_valid), .result_ready(result_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    prod = $signed(mac_x) * $signed(mac_w);
    mac  = prod[23:8] + (mac_acc_loopback ? acc : 16'd0);
  end

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    rd_d <= rd_en;
    acc  <= mac;
    if (rd_en) begin
      x_rdata <= x_mem[x_addr];
      w_rdata <= w_mem[w_addr];
    end
  end

  always @(negedge clk) begin
    if (rd_d === 1'b1) lb_log.push_back(mac_acc_loopback);
    if (rd_en === 1'b1) addr_log.push_back(x_addr);
  end

  function automatic logic [15:0] dot(input int l, input int xb, input int wb);
    logic [15:0]        a;
    logic signed [31:0] p;
    logic [7:0]         xa, wa;
    a = 16'd0;
    for (int i = 0; i < l; i++) begin
      xa = 8'(xb + i);
      wa = 8'(wb + i);
      p  = $signed(x_mem[xa]) * $signed(w_mem[wa]);
      a  = a + p[23:8];
    end
`ifdef MAC_SEQ_RELU_EN
    if (a[15]) a = 16'd0;
`endif
    return a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic start_job(input int l, input int xb, input int wb, input logic [15:0] e);
    lb_log.delete();
    addr_log.delete();
    len         = 8'(l);
    x_base      = 8'(xb);
    w_base      = 8'(wb);
    start_valid = 1'b1;
    chk("start_ready_idle", 32'(start_ready), 32'd1);
    exp_q.push_back(e);
    lat_q.push_back(l == 0 ? 1 : l + 2);
    hs = cyc;
    @(negedge clk);
    start_valid = 1'b0;
    len         = 8'($urandom);
    x_base      = 8'($urandom);
    w_base      = 8'($urandom);
  endtask

  task automatic finish_job(input int l, input int hold);
    int          n;
    logic [15:0] e;
    n = 0;
    while (result_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    if (result_valid !== 1'b1) begin
      chk("result_timeout", 32'(result_valid), 32'd1);
      void'(lat_q.pop_front());
      return;
    end
    chk("latency", 32'(cyc - hs), 32'(lat_q.pop_front()));
    chk("result", 32'(result), 32'(e));
    chk("loopback_count", 32'(lb_log.size()), 32'(l));
    for (int i = 0; i < lb_log.size(); i++)
      chk("loopback_pattern", 32'(lb_log[i]), (i != 0) ? 32'd1 : 32'd0);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_result", 32'(result), 32'(e));
      chk("hold_valid", 32'(result_valid), 32'd1);
      chk("hold_start_ready", 32'(start_ready), 32'd0);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk("post_valid", 32'(result_valid), 32'd0);
    chk("post_start_ready", 32'(start_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    rst_n        = 1'b0;
    start_valid  = 1'b0;
    result_ready = 1'b0;
    len          = 8'd0;
    x_base       = 8'd0;
    w_base       = 8'd0;
    for (int i = 0; i < 256; i++) begin
      x_mem[i] = 16'($urandom_range(0, 1023)) - 16'd512;
      w_mem[i] = 16'($urandom_range(0, 1023)) - 16'd512;
    end
    x_mem[4] = 16'h0100; x_mem[5] = 16'h0200; x_mem[6] = 16'h0300;
    w_mem[16] = 16'h0080; w_mem[17] = 16'h0080; w_mem[18] = 16'h0100;
    x_mem[255] = 16'h0100; x_mem[0] = 16'hFD00;
    w_mem[32] = 16'h0100; w_mem[33] = 16'h0100;

    repeat (2) @(negedge clk);
    chk("rst_start_ready", 32'(start_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_x_addr", 32'(x_addr), 32'd0);
    chk("rst_w_addr", 32'(w_addr), 32'd0);
    chk("rst_loopback", 32'(mac_acc_loopback), 32'd0);
    chk("x_select", 32'(mac_x_select), 32'd1);
    chk("w_select", 32'(mac_w_select), 32'd1);
    chk("reg_enable", 32'(mac_reg_enable), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1.0*0.5 + 2.0*0.5 + 3.0*1.0 = 4.5
    start_job(3, 4, 16, 16'h0480);
    finish_job(3, 0);
    chk("addr_a_count", 32'(addr_log.size()), 32'd3);
    if (addr_log.size() == 3) begin
      chk("addr_a0", 32'(addr_log[0]), 32'd4);
      chk("addr_a2", 32'(addr_log[2]), 32'd6);
    end

    start_job(0, 7, 9, 16'h0000);
    finish_job(0, 0);
    chk("len0_no_rd", 32'(addr_log.size()), 32'd0);

    // 1.0*1.0 + (-3.0)*1.0 = -2.0, address wraps 255 -> 0, result held 4 cycles
    start_job(2, 255, 32, NEG2_EXP);
    finish_job(2, 4);
    chk("wrap_count", 32'(addr_log.size()), 32'd2);
    if (addr_log.size() == 2) begin
      chk("wrap_addr0", 32'(addr_log[0]), 32'd255);
      chk("wrap_addr1", 32'(addr_log[1]), 32'd0);
    end

    start_job(1, 4, 16, 16'h0080);
    finish_job(1, 0);

    start_job(4, 60, 70, dot(4, 60, 70));
    start_valid = 1'b1;
    len         = 8'd2;
    x_base      = 8'd4;
    chk("busy_in_fetch", 32'(busy), 32'd1);
    chk("start_ready_in_fetch", 32'(start_ready), 32'd0);
    @(negedge clk);
    start_valid = 1'b0;
    finish_job(4, 0);

    start_job(5, 100, 110, dot(5, 100, 110));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_rd_en", 32'(rd_en), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_start_ready", 32'(start_ready), 32'd1);
    chk("midrst_x_addr", 32'(x_addr), 32'd0);
    chk("midrst_w_addr", 32'(w_addr), 32'd0);
    chk("midrst_loopback", 32'(mac_acc_loopback), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    void'(exp_q.pop_front());
    void'(lat_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (result_valid !== 1'b0 || rd_en !== 1'b0) seen = 1;
    end
    chk("no_result_after_reset", 32'(seen), 32'd0);

    start_job(6, 200, 230, dot(6, 200, 230));
    finish_job(6, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8: x/w memory address width.
REQ-002 Parameter LEN_W, default 8: vector length width; lengths 0..2^LEN_W-1.
REQ-003 Q format is Q_INT.Q_FRAC signed fixed point from package definitions; Q = Q_INT+Q_FRAC bits.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start_valid  in  1  job request; start_ready  out  1  job accepted when both high.
REQ-007 len  in  LEN_W  element count; x_base, w_base  in  ADDR_W  start addresses; sampled on start handshake.
REQ-008 rd_en  out  1  memory read strobe; x_addr, w_addr  out  ADDR_W  read addresses.
REQ-009 x_rdata, w_rdata  in  Q  memory data, valid exactly 1 cycle after rd_en.
REQ-010 mac_x, mac_w  out  Q  operands to MAC stage; mac_x_select, mac_w_select, mac_reg_enable, mac_acc_loopback  out  1  MAC controls.
REQ-011 mac  in  Q  combinational MAC sum (product plus gated accumulator).
REQ-012 result_valid  out  1; result_ready  in  1; result  out  Q  dot-product result; busy  out  1  high in any state except IDLE.

Function
REQ-013 States IDLE, FETCH, DRAIN, OUT; start_ready SHALL be high only in IDLE.
REQ-014 IDLE: on start handshake with len>0 -> FETCH, element counter k=0; with len=0 -> OUT, result=0.
REQ-015 FETCH: rd_en=1, x_addr=x_base+k, w_addr=w_base+k (modulo 2^ADDR_W, wrap-around permitted); k increments each cycle; after k=len-1 -> DRAIN.
REQ-016 DRAIN: rd_en=0 for exactly one cycle; at its end result<=mac, -> OUT.
REQ-017 mac_x=x_rdata, mac_w=w_rdata pass-through; mac_x_select=1, mac_w_select=1, mac_reg_enable=0 constantly.
REQ-018 mac_acc_loopback SHALL be 0 in the cycle carrying data for element 0 and in all non-data cycles, 1 in cycles carrying data for elements 1..len-1.
REQ-019 OUT: result_valid=1, result held stable until result_ready=1; then -> IDLE; no new start accepted in the same cycle.
REQ-020 Latency: result_valid asserts len+2 cycles after the start-handshake cycle for len>0; 1 cycle after for len=0.
REQ-021 Arithmetic: result is the wrapped Q-bit sum delivered by mac; no saturation added by this block.
REQ-022 start_valid while not IDLE SHALL be ignored; len/bases changing mid-job SHALL have no effect.

Reset
REQ-023 reset low SHALL force IDLE immediately: start_ready=1, busy=0, rd_en=0, result_valid=0, result=0, x_addr=w_addr=0, k=0, mac_acc_loopback=0.
REQ-024 Reset asserted mid-job SHALL abandon the job; no result is produced after release.

Configuration
REQ-025 Macro MAC_SEQ_RELU_EN defined: value captured in DRAIN SHALL be 0 if mac is negative, else mac; len=0 result still 0.
REQ-026 MAC_SEQ_RELU_EN undefined: result is mac unmodified, negative values passed through.

Verification
REQ-027 len=3, x=[1.0,2.0,3.0], w=[0.5,0.5,1.0] -> result=4.5, result_valid at start+5 cycles, loopback pattern 0,1,1.
REQ-028 len=0 -> result_valid next cycle, result=0, rd_en never asserted.
REQ-029 x_base=2^ADDR_W-1, len=2 -> x_addr sequence 2^ADDR_W-1, 0.
REQ-030 Result -2.0 with result_ready held low 4 cycles -> result stable -2.0 (0 with MAC_SEQ_RELU_EN), start_ready low throughout.
REQ-031 reset low during FETCH of len=5 job -> outputs at reset values same cycle; no result_valid after release; next job correct.
REQ-032 start_valid pulsed during FETCH -> ignored, current job result unaffected.
